// File: rtl/reg_read_stage.sv
`default_nettype none
// ============================================================================
// Module      : reg_read_stage
// Description : Register-read pipeline stage. Resolves the two source
//               operands of a decoded uop (architectural register file,
//               constant/fake ids, pc and immediate), tracks in-flight
//               destinations in a one-bit-per-register scoreboard, stalls on
//               hazards and presents the resolved uop through a registered
//               valid/ready output (latency 1). A writeback port updates the
//               register file and retires scoreboard entries. Illegal ids
//               raise a sticky error flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Register id encoding (8 bits):
//   0x00 rnil  -> 0 (also "no destination")
//   0x01 rv0   -> 0
//   0x02 rv8   -> 8
//   0x03 rip   -> in_pc
//   0x04 rimm  -> in_imm
//   0x05..0x7F undefined fake codes (operand 0, err)
//   0x80+n     real register n (rax=0x80, rcx=0x81, rdx=0x82, ...);
//              n >= REG_FILE_SIZE is illegal (operand 0, err)
// ----------------------------------------------------------------------------
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   in_valid/in_ready            upstream handshake
//   in_src_a, in_src_b, in_dst   source / destination register ids
//   in_pc, in_imm                values for rip / rimm
//   out_valid/out_ready          downstream handshake
//   out_a, out_b, out_dst        resolved operands and destination
//   wb_valid, wb_dst, wb_data    writeback port
//   err                          sticky illegal-register flag
// ----------------------------------------------------------------------------
// Configuration macro:
//   REG_READ_BYPASS_EN  forward same-cycle writeback data to matching sources
//                       instead of stalling on them.
// ============================================================================
module reg_read_stage #(
  parameter int REG_FILE_SIZE = 20,
  parameter int DATA_W        = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  // upstream
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_src_a,
  input  logic [7:0]        in_src_b,
  input  logic [7:0]        in_dst,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_imm,
  // downstream
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [7:0]        out_dst,
  // writeback
  input  logic              wb_valid,
  input  logic [7:0]        wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  // status
  output logic              err
);

  localparam logic [7:0] c_rnil = 8'h00;
  localparam logic [7:0] c_rv0  = 8'h01;
  localparam logic [7:0] c_rv8  = 8'h02;
  localparam logic [7:0] c_rip  = 8'h03;
  localparam logic [7:0] c_rimm = 8'h04;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]        r_regs [REG_FILE_SIZE];
  logic [REG_FILE_SIZE-1:0] r_busy;
  logic                     r_out_valid;
  logic [DATA_W-1:0]        r_out_a;
  logic [DATA_W-1:0]        r_out_b;
  logic [7:0]               r_out_dst;
  logic                     r_err;

  // --------------------------------------------------------------------------
  // Writeback decode
  // --------------------------------------------------------------------------
  logic w_wb_legal;   // wb_dst names an existing real register
  logic w_wb_write;   // writeback actually updates the register file
  logic w_wb_bad;     // writeback to a fake or out-of-range id

  assign w_wb_legal = wb_dst[7] && (int'(wb_dst[6:0]) < REG_FILE_SIZE);
  assign w_wb_write = wb_valid && w_wb_legal;
  assign w_wb_bad   = wb_valid && !w_wb_legal;

  // --------------------------------------------------------------------------
  // Source operand resolution (one instance per source port)
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_src_val   [2];
  logic              w_src_stall [2];
  logic              w_src_bad   [2];

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [7:0]        w_id;
    logic              w_legal_real;
    logic              w_wb_match;
    logic [DATA_W-1:0] w_reg_val;
    logic              w_reg_busy;
    logic [DATA_W-1:0] w_val;
    logic              w_bad;

    assign w_id         = (s == 0) ? in_src_a : in_src_b;
    assign w_legal_real = w_id[7] && (int'(w_id[6:0]) < REG_FILE_SIZE);
    assign w_wb_match   = w_wb_write && (wb_dst == w_id);

    // Register file / scoreboard read port.
    always_comb begin
      w_reg_val  = '0;
      w_reg_busy = 1'b0;
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        if (w_id[6:0] == 7'(i)) begin
          w_reg_val  = r_regs[i];
          w_reg_busy = r_busy[i];
        end
      end
    end

    always_comb begin
      w_val = '0;
      w_bad = 1'b0;
      if (w_id[7]) begin
        if (w_legal_real) begin
`ifdef REG_READ_BYPASS_EN
          w_val = w_wb_match ? wb_data : w_reg_val;
`else
          w_val = w_reg_val;
`endif
        end else begin
          w_bad = 1'b1;
        end
      end else begin
        case (w_id)
          c_rnil, c_rv0: w_val = '0;
          c_rv8:         w_val = DATA_W'(8);
          c_rip:         w_val = in_pc;
          c_rimm:        w_val = in_imm;
          default:       w_bad = 1'b1;
        endcase
      end
    end

    assign w_src_val[s] = w_val;
    assign w_src_bad[s] = w_bad;
`ifdef REG_READ_BYPASS_EN
    // A busy source being written this very cycle is satisfied by forwarding.
    assign w_src_stall[s] = w_legal_real && w_reg_busy && !w_wb_match;
`else
    // Without forwarding the source waits one cycle for the register file.
    assign w_src_stall[s] = w_legal_real && w_reg_busy;
    logic w_unused_match;
    assign w_unused_match = w_wb_match;
`endif
  end

  // --------------------------------------------------------------------------
  // Destination decode
  // --------------------------------------------------------------------------
  logic w_dst_legal_real;
  logic w_dst_busy;
  logic w_dst_bad;

  assign w_dst_legal_real = in_dst[7] && (int'(in_dst[6:0]) < REG_FILE_SIZE);
  // Constant ids (rv0/rv8/rip/rimm) as destination simply mean "no write".
  assign w_dst_bad = in_dst[7] ? !w_dst_legal_real : (in_dst > c_rimm);

  always_comb begin
    w_dst_busy = 1'b0;
    for (int i = 0; i < REG_FILE_SIZE; i++) begin
      if (in_dst[6:0] == 7'(i)) begin
        w_dst_busy = r_busy[i] && w_dst_legal_real;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_stall;
  logic w_xfer;
  logic w_xfer_bad;

  // The destination check blocks a second in-flight writer of the same
  // register, so one busy bit per register is sufficient.
  assign w_stall    = in_valid && (w_src_stall[0] || w_src_stall[1] || w_dst_busy);
  assign in_ready   = reset_n && !w_stall && (!r_out_valid || out_ready);
  assign w_xfer     = in_valid && in_ready;
  assign w_xfer_bad = w_xfer && (w_src_bad[0] || w_src_bad[1] || w_dst_bad);

  // --------------------------------------------------------------------------
  // Per-register write/set strobes
  // --------------------------------------------------------------------------
  logic [REG_FILE_SIZE-1:0] w_wb_hit;
  logic [REG_FILE_SIZE-1:0] w_busy_set;

  for (genvar g = 0; g < REG_FILE_SIZE; g++) begin : g_strobe
    assign w_wb_hit[g]   = w_wb_write && (wb_dst[6:0] == 7'(g));
    assign w_busy_set[g] = w_xfer && w_dst_legal_real && (in_dst[6:0] == 7'(g));
  end

  // --------------------------------------------------------------------------
  // Register file and scoreboard
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        if (w_wb_hit[i]) begin
          r_regs[i] <= wb_data;
        end
        // A new issue to the register overrides a retiring writeback.
        if (w_busy_set[i]) begin
          r_busy[i] <= 1'b1;
        end else if (w_wb_hit[i]) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register and sticky error
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_dst   <= c_rnil;
      r_err       <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_a     <= w_src_val[0];
        r_out_b     <= w_src_val[1];
        r_out_dst   <= in_dst;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_xfer_bad || w_wb_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_a     = r_out_a;
  assign out_b     = r_out_b;
  assign out_dst   = r_out_dst;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_read_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_read_stage
// Description : Self-checking bench for reg_read_stage. Directed scenarios
//               followed by randomized traffic, all checked against an
//               array-based behavioural model of the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_read_stage;

  localparam int N = 20;
  localparam int W = 64;

  localparam logic [7:0] RNIL = 8'h00;
  localparam logic [7:0] RV0  = 8'h01;
  localparam logic [7:0] RV8  = 8'h02;
  localparam logic [7:0] RIP  = 8'h03;
  localparam logic [7:0] RIMM = 8'h04;
  localparam logic [7:0] RAX  = 8'h80;
  localparam logic [7:0] RCX  = 8'h81;
  localparam logic [7:0] RDX  = 8'h82;
  localparam logic [7:0] RBX  = 8'h83;
  localparam logic [7:0] RLST = 8'h93;  // highest legal real register

`ifdef REG_READ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_src_a, in_src_b, in_dst;
  logic [W-1:0] in_pc, in_imm;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a, out_b;
  logic [7:0]   out_dst;
  logic         wb_valid;
  logic [7:0]   wb_dst;
  logic [W-1:0] wb_data;
  logic         err;

  always #5 clk = ~clk;

  reg_read_stage #(.REG_FILE_SIZE(N), .DATA_W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_dst(in_dst),
    .in_pc(in_pc), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_dst(out_dst),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  logic [W-1:0] m_regs [N];
  bit           m_busy [N];
  bit           m_out_valid;
  logic [W-1:0] m_out_a, m_out_b;
  logic [7:0]   m_out_dst;
  bit           m_err;
  bit           exp_ready;
  bit           obs_ready;
  bit           obs_xfer;
  logic [W-1:0] saved_a;
  int           k;

  task automatic check_value(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic bit legal(input logic [7:0] id);
    return id[7] && (int'(id[6:0]) < N);
  endfunction

  task automatic resolve(input logic [7:0] id, output logic [W-1:0] val,
                         output bit bad, output bit stall);
    val = '0; bad = 1'b0; stall = 1'b0;
    if (legal(id)) begin
      if (BYP && wb_valid && wb_dst == id) val = wb_data;
      else begin
        val   = m_regs[int'(id[6:0])];
        stall = m_busy[int'(id[6:0])];
      end
    end else begin
      case (id)
        RNIL, RV0: val = '0;
        RV8:       val = 64'd8;
        RIP:       val = in_pc;
        RIMM:      val = in_imm;
        default:   bad = 1'b1;
      endcase
    end
  endtask

  // One clock: check in_ready for the driven inputs, advance the model at
  // the edge, then check every output against the model.
  task automatic cycle();
    logic [W-1:0] va, vb;
    bit ba, bb, sa, sb, stall, dbad;
    #1;
    resolve(in_src_a, va, ba, sa);
    resolve(in_src_b, vb, bb, sb);
    stall = in_valid && (sa || sb || (legal(in_dst) && m_busy[int'(in_dst[6:0])]));
    exp_ready = reset_n && !stall && (!m_out_valid || out_ready);
    obs_ready = in_ready;
    obs_xfer  = in_valid && in_ready;
    check_value("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
    dbad = in_dst[7] ? !legal(in_dst) : (in_dst > RIMM);
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
      m_out_valid = 1'b0; m_out_a = '0; m_out_b = '0; m_out_dst = RNIL; m_err = 1'b0;
    end else begin
      if (wb_valid && !legal(wb_dst)) m_err = 1'b1;
      if (in_valid && exp_ready) begin
        m_out_valid = 1'b1; m_out_a = va; m_out_b = vb; m_out_dst = in_dst;
        if (ba || bb || dbad) m_err = 1'b1;
      end else if (out_ready) m_out_valid = 1'b0;
      if (wb_valid && legal(wb_dst)) begin
        m_regs[int'(wb_dst[6:0])] = wb_data;
        m_busy[int'(wb_dst[6:0])] = 1'b0;
      end
      if (in_valid && exp_ready && legal(in_dst)) m_busy[int'(in_dst[6:0])] = 1'b1;
    end
    #1;
    check_value("out_valid", {63'd0, out_valid}, {63'd0, m_out_valid});
    check_value("out_a", out_a, m_out_a);
    check_value("out_b", out_b, m_out_b);
    check_value("out_dst", {56'd0, out_dst}, {56'd0, m_out_dst});
    check_value("err", {63'd0, err}, {63'd0, m_err});
  endtask

  task automatic uop(input bit v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
    in_valid = v; in_src_a = a; in_src_b = b; in_dst = d;
  endtask

  task automatic wb(input bit v, input logic [7:0] d, input logic [W-1:0] data);
    wb_valid = v; wb_dst = d; wb_data = data;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; cycle(); reset_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_src();
    logic [7:0] tbl [10] = '{RNIL, RV0, RV8, RIP, RIMM, RAX, RCX, RDX, RBX, RLST};
    if ($urandom_range(0, 99) < 3) return ($urandom_range(0, 1) == 0) ? 8'h20 : 8'h94;
    return tbl[$urandom_range(0, 9)];
  endfunction

  function automatic logic [7:0] rand_reg();
    logic [7:0] tbl [5] = '{RAX, RCX, RDX, RBX, RLST};
    return tbl[$urandom_range(0, 4)];
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    m_out_valid = 1'b0; m_out_a = '0; m_out_b = '0; m_out_dst = RNIL; m_err = 1'b0;
    reset_n = 1'b0; out_ready = 1'b1; in_pc = '0; in_imm = '0;
    uop(0, RNIL, RNIL, RNIL); wb(0, RNIL, '0);

    // Reset state
    cycle(); cycle();
    check_value("rst_ready", {63'd0, obs_ready}, 64'd0);
    check_value("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_value("rst_out_dst", {56'd0, out_dst}, {56'd0, RNIL});
    reset_n = 1'b1;

    // Constant and immediate operands
    in_imm = 64'h1234; uop(1, RV8, RIMM, RNIL);
    cycle();
    check_value("const_a", out_a, 64'd8);
    check_value("const_b", out_b, 64'h1234);
    check_value("const_err", {63'd0, err}, 64'd0);
    uop(0, RNIL, RNIL, RNIL); cycle();

    // Writeback then read; RAW stall on busy rcx
    wb(1, RAX, 64'hDEAD); cycle(); wb(0, RNIL, '0);
    uop(1, RAX, RNIL, RCX); cycle();
    check_value("rax_read", out_a, 64'hDEAD);
    uop(1, RCX, RNIL, RNIL);
    cycle(); check_value("rcx_stall0", {63'd0, obs_ready}, 64'd0);
    cycle(); check_value("rcx_stall1", {63'd0, obs_ready}, 64'd0);
    wb(1, RCX, 64'h5); cycle(); wb(0, RNIL, '0);
    k = 0;
    while (!obs_xfer && k < 4) begin cycle(); k++; end
    check_value("rcx_accepted", {63'd0, obs_xfer}, 64'd1);
    check_value("rcx_read", out_a, 64'h5);
    uop(0, RNIL, RNIL, RNIL); cycle();

    // Writeback to a busy source in the same cycle it is requested
    uop(1, RNIL, RNIL, RCX); cycle();
    uop(1, RCX, RNIL, RNIL); wb(1, RCX, 64'h7); cycle(); wb(0, RNIL, '0);
    check_value("byp_ready", {63'd0, obs_ready}, {63'd0, BYP});
    k = 0;
    while (!obs_xfer && k < 4) begin cycle(); k++; end
    check_value("byp_delay", 64'(k), BYP ? 64'd0 : 64'd1);
    check_value("byp_a", out_a, 64'h7);
    uop(0, RNIL, RNIL, RNIL); cycle();

    // Downstream backpressure
    out_ready = 1'b0; uop(1, RV8, RNIL, RNIL); cycle();
    saved_a = out_a;
    in_imm = 64'h55; uop(1, RIMM, RV0, RNIL);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_value("bp_ready", {63'd0, obs_ready}, 64'd0);
      check_value("bp_hold_a", out_a, saved_a);
    end
    out_ready = 1'b1; cycle();
    check_value("bp_accept", {63'd0, obs_xfer}, 64'd1);
    check_value("bp_new_a", out_a, 64'h55);
    uop(0, RNIL, RNIL, RNIL); cycle();

    // Illegal ids set a sticky error
    uop(1, 8'h20, RNIL, RNIL); cycle(); uop(0, RNIL, RNIL, RNIL);
    check_value("bad_src_a", out_a, 64'd0);
    check_value("bad_src_err", {63'd0, err}, 64'd1);
    cycle(); cycle();
    check_value("err_sticky", {63'd0, err}, 64'd1);
    do_reset();
    check_value("err_cleared", {63'd0, err}, 64'd0);
    wb(1, 8'h94, 64'h123); cycle(); wb(0, RNIL, '0);
    check_value("bad_wb_err", {63'd0, err}, 64'd1);

    // Reset with a held output and a busy register
    out_ready = 1'b0; uop(1, RNIL, RNIL, RDX); cycle(); uop(0, RNIL, RNIL, RNIL);
    reset_n = 1'b0; wb(1, RDX, 64'h99); cycle(); wb(0, RNIL, '0); reset_n = 1'b1;
    check_value("midrst_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1; uop(1, RDX, RNIL, RNIL); cycle();
    check_value("midrst_ready", {63'd0, obs_ready}, 64'd1);
    check_value("midrst_a", out_a, 64'd0);
    uop(0, RNIL, RNIL, RNIL); cycle();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      reset_n   = ($urandom_range(0, 199) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_pc     = {$urandom, $urandom};
      in_imm    = {$urandom, $urandom};
      uop($urandom_range(0, 9) < 7, rand_src(), rand_src(),
          ($urandom_range(0, 2) == 0) ? RNIL : rand_reg());
      if ($urandom_range(0, 99) < 2) wb(1, 8'h94, {$urandom, $urandom});
      else wb($urandom_range(0, 9) < 4, rand_reg(), {$urandom, $urandom});
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
